rr_ring_arbiter: RTL and testbench
==================================

RR_RING_ARBITER -- requirements
Module: rr_ring_arbiter

Interface
REQ-001 SHALL have parameter N, default 8, giving the requester count (fixed at 8; other values are unsupported).
REQ-002 SHALL have parameter MAX_HOLD, default 16, giving the maximum grant length in cycles when timeout is compiled in (range 2..255).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port en, input, 1 bit: when high, new grants are permitted.
REQ-006 SHALL have port req, input, 8 bits: per-requester request levels.
REQ-007 SHALL have port done, input, 1 bit: the current owner releases the resource (pulse).
REQ-008 SHALL have port grant, output, 8 bits: registered one-hot grant, or all zero.
REQ-009 SHALL have port gnt_id, output, 3 bits: binary index of the grant bit; 0 when no grant is active.
REQ-010 SHALL have port busy, output, 1 bit: high while in GRANT.
REQ-011 SHALL have port timeout, output, 1 bit: one-cycle pulse on a forced release.

Function
REQ-012 SHALL have a two-state FSM: IDLE (no grant) and GRANT (exactly one grant bit set).
REQ-013 SHALL keep a one-hot priority pointer ptr[7:0]; the highest priority goes to the ptr bit, then ascending index with wrap 7->0.
REQ-014 IDLE: if en=1 and req!=0, the next edge SHALL load grant with the first requesting bit at or after ptr, and enter GRANT (latency 1 cycle).
REQ-015 IDLE with en=0 or req=0: grant SHALL stay 0 and ptr SHALL be unchanged.
REQ-016 GRANT SHALL be held while req[owner]=1 and done=0; other requests SHALL be ignored meanwhile.
REQ-017 GRANT release on done=1 or req[owner]=0: ptr SHALL be loaded with the owner bit rotated left by one (bit 7 -> bit 0).
REQ-018 On a release with en=1 and req!=0, the same edge SHALL grant the next winner using the updated ptr (back-to-back, no idle bubble); the former owner SHALL have lowest priority.
REQ-019 On a release with en=0 or req=0, the FSM SHALL return to IDLE with grant=0.
REQ-020 en=0 during GRANT SHALL NOT revoke the current grant; it only blocks the follow-on grant.
REQ-021 done=1 in IDLE SHALL be ignored.
REQ-022 grant SHALL never have more than one bit set; gnt_id and busy SHALL be registered alongside grant and consistent with it every cycle.

Reset
REQ-023 rst_n=0 SHALL immediately force grant=0, gnt_id=0, busy=0, timeout=0, ptr=8'b00000001, state=IDLE, and hold counter=0.
REQ-024 Reset asserted mid-grant SHALL drop the grant asynchronously with no release pulse; the first arbitration after deassertion SHALL start from requester 0.

Configuration
REQ-025 Macro RR_TIMEOUT_EN defined: an 8-bit hold counter SHALL clear on every new grant and increment each GRANT cycle.
REQ-026 With RR_TIMEOUT_EN defined, the MAX_HOLD-th GRANT cycle SHALL force a release per REQ-017/018 and pulse timeout high for one cycle.
REQ-027 With RR_TIMEOUT_EN defined, a forced release SHALL take effect even if req[owner] remains high, and that owner SHALL become lowest priority.
REQ-028 Macro RR_TIMEOUT_EN undefined: no counter SHALL exist, timeout SHALL be tied 0, and a grant SHALL be held indefinitely per REQ-016.

Verification
REQ-029 Reset, en=1, req=8'b00000110 -> one cycle later grant=8'b00000010, gnt_id=1, busy=1.
REQ-030 After grant to req1, pulse done with req=8'b10000110 -> next edge grant=8'b00000100 (back-to-back), ptr=8'b00000100; next done -> grant=8'b10000000.
REQ-031 Owner 7 releases with req=8'b10000001 -> grant=8'b00000001 (wrap-around); then owner 0 holds with req=8'b10000001 -> grant stays 0x01 until done.
REQ-032 req=8'hFF held and done pulsed each grant -> grants cycle 0,1,...,7,0 with no repeats or gaps; en=0 at owner 3's release -> grant=0, busy=0, state=IDLE.
REQ-033 RR_TIMEOUT_EN defined, MAX_HOLD=16, req=8'b00010001 held, no done -> grant 0x01 for exactly 16 cycles, timeout pulse, then grant=8'b00010000; undefined -> grant 0x01 indefinitely, timeout=0.
REQ-034 rst_n low mid-grant with req=8'b00001000 -> grant=0 immediately; after release, grant=8'b00001000 one edge later.

Source files
------------

// File: rtl/rr_ring_arbiter.sv
// Eight-way round-robin ring arbiter with a hold-until-release grant and a rotating one-hot priority pointer.
// Optional forced release after MAX_HOLD grant cycles is compiled in with `define RR_TIMEOUT_EN.
module rr_ring_arbiter #(
   parameter int N        = 8,
   parameter int MAX_HOLD = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic [N-1:0] req,
   input  logic         done,
   output logic [N-1:0] grant,
   output logic [2:0]   gnt_id,
   output logic         busy,
   output logic         timeout
);

   typedef enum logic [0:0] {IDLE = 1'b0, GRANT = 1'b1} state_t;

   if (N != 8) begin : g_bad_n
      $error("rr_ring_arbiter supports N == 8 only");
   end
   if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_hold
      $error("rr_ring_arbiter MAX_HOLD must lie in 2..255");
   end

   state_t         state_r, state_nxt_s;
   logic [N-1:0]   ptr_r, ptr_nxt_s, base_ptr_s, win_s, grant_nxt_s;
   logic [2:0]     gnt_id_nxt_s;
   logic           busy_nxt_s, timeout_nxt_s;
   logic           owner_req_s, release_s, load_s, forced_s;

   function automatic logic [N-1:0] rotl1(input logic [N-1:0] v);
      return {v[N-2:0], v[N-1]};
   endfunction

   // First set bit of r at or above the one-hot pointer p, wrapping to the lowest set bit.
   function automatic logic [N-1:0] rr_pick(input logic [N-1:0] r, input logic [N-1:0] p);
      logic [N-1:0] masked;
      logic [N-1:0] src;
      masked = r & ~(p - {{(N-1){1'b0}}, 1'b1});
      src    = (masked != {N{1'b0}}) ? masked : r;
      return src & (~src + {{(N-1){1'b0}}, 1'b1});
   endfunction

   function automatic logic [2:0] to_idx(input logic [N-1:0] oh);
      logic [2:0] idx;
      idx = 3'd0;
      for (int i = 0; i < N; i++) begin
         if (oh[i]) idx = idx | 3'(i);
         else       idx = idx;
      end
      return idx;
   endfunction

`ifdef RR_TIMEOUT_EN
   logic [7:0] hold_r;

   assign forced_s = (state_r == GRANT) && (hold_r == 8'(MAX_HOLD - 1));

   // Hold counter: cleared on every fresh grant, counts cycles spent in GRANT.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                 hold_r <= 8'd0;
      else if (load_s)            hold_r <= 8'd0;
      else if (state_r == GRANT)  hold_r <= hold_r + 8'd1;
      else                        hold_r <= 8'd0;
   end
`else
   assign forced_s = 1'b0;
`endif

   // State and pointer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
         ptr_r   <= {{(N-1){1'b0}}, 1'b1};
      end else begin
         state_r <= state_nxt_s;
         ptr_r   <= ptr_nxt_s;
      end
   end

   // Next-state logic: release detection, pointer update and winner selection.
   always_comb begin
      owner_req_s = |(req & grant);
      if (state_r == GRANT) release_s = done | ~owner_req_s | forced_s;
      else                  release_s = 1'b0;
      base_ptr_s = release_s ? rotl1(grant) : ptr_r;
      ptr_nxt_s  = base_ptr_s;
      load_s     = en && (req != {N{1'b0}}) && ((state_r == IDLE) || release_s);
      win_s      = rr_pick(req, base_ptr_s);
      if (load_s)                                state_nxt_s = GRANT;
      else if ((state_r == GRANT) && !release_s) state_nxt_s = GRANT;
      else                                       state_nxt_s = IDLE;
   end

   // Output decode: values to be registered alongside the state.
   always_comb begin
      if (load_s)                    grant_nxt_s = win_s;
      else if (state_nxt_s == GRANT) grant_nxt_s = grant;
      else                           grant_nxt_s = {N{1'b0}};
      gnt_id_nxt_s  = to_idx(grant_nxt_s);
      busy_nxt_s    = (state_nxt_s == GRANT);
      // A release is only reported as forced when nothing else would have released it.
      timeout_nxt_s = forced_s & ~done & owner_req_s;
   end

   // Registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant   <= {N{1'b0}};
         gnt_id  <= 3'd0;
         busy    <= 1'b0;
         timeout <= 1'b0;
      end else begin
         grant   <= grant_nxt_s;
         gnt_id  <= gnt_id_nxt_s;
         busy    <= busy_nxt_s;
         timeout <= timeout_nxt_s;
      end
   end

endmodule

// File: tb/tb_rr_ring_arbiter.sv
// Directed, table-driven bench for rr_ring_arbiter; hold/timeout branch follows RR_TIMEOUT_EN.
module tb_rr_ring_arbiter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic [7:0] req = 8'h00;
   logic       done = 1'b0;
   logic [7:0] grant;
   logic [2:0] gnt_id;
   logic       busy;
   logic       timeout;

   int errors = 0;
   int checks = 0;

   typedef struct {
      logic       en;
      logic [7:0] req;
      logic       done;
      logic [7:0] g;
      logic [2:0] id;
      logic       b;
   } vec_t;

   vec_t vecs[25];

   rr_ring_arbiter #(.N(8), .MAX_HOLD(16)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .req(req), .done(done),
      .grant(grant), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %02h expected %02h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [7:0] g, input logic [2:0] id,
                          input logic b, input logic t);
      chk({name, " grant"},   grant,            g);
      chk({name, " gnt_id"},  {5'd0, gnt_id},   {5'd0, id});
      chk({name, " busy"},    {7'd0, busy},     {7'd0, b});
      chk({name, " timeout"}, {7'd0, timeout},  {7'd0, t});
   endtask

   task automatic step(input logic e, input logic [7:0] r, input logic d);
      @(negedge clk);
      en = e; req = r; done = d;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; en = 1'b0; req = 8'h00; done = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 8'h06, 1'b0, 8'h02, 3'd1, 1'b1};
      vecs[1]  = '{1'b1, 8'h86, 1'b1, 8'h04, 3'd2, 1'b1};
      vecs[2]  = '{1'b1, 8'h86, 1'b1, 8'h80, 3'd7, 1'b1};
      vecs[3]  = '{1'b1, 8'h81, 1'b1, 8'h01, 3'd0, 1'b1};
      vecs[4]  = '{1'b1, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
      vecs[5]  = '{1'b1, 8'h81, 1'b0, 8'h01, 3'd0, 1'b1};
      vecs[6]  = '{1'b1, 8'hFF, 1'b0, 8'h01, 3'd0, 1'b1};
      vecs[7]  = '{1'b1, 8'hFF, 1'b1, 8'h02, 3'd1, 1'b1};
      vecs[8]  = '{1'b1, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1};
      vecs[9]  = '{1'b1, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1};
      vecs[10] = '{1'b1, 8'hFF, 1'b1, 8'h10, 3'd4, 1'b1};
      vecs[11] = '{1'b1, 8'hFF, 1'b1, 8'h20, 3'd5, 1'b1};
      vecs[12] = '{1'b1, 8'hFF, 1'b1, 8'h40, 3'd6, 1'b1};
      vecs[13] = '{1'b1, 8'hFF, 1'b1, 8'h80, 3'd7, 1'b1};
      vecs[14] = '{1'b1, 8'hFF, 1'b1, 8'h01, 3'd0, 1'b1};
      vecs[15] = '{1'b1, 8'hFF, 1'b1, 8'h02, 3'd1, 1'b1};
      vecs[16] = '{1'b1, 8'hFF, 1'b1, 8'h04, 3'd2, 1'b1};
      vecs[17] = '{1'b1, 8'hFF, 1'b1, 8'h08, 3'd3, 1'b1};
      vecs[18] = '{1'b0, 8'hFF, 1'b1, 8'h00, 3'd0, 1'b0};
      vecs[19] = '{1'b0, 8'hFF, 1'b0, 8'h00, 3'd0, 1'b0};
      vecs[20] = '{1'b1, 8'hFF, 1'b1, 8'h10, 3'd4, 1'b1};
      vecs[21] = '{1'b0, 8'h10, 1'b0, 8'h10, 3'd4, 1'b1};
      vecs[22] = '{1'b1, 8'h00, 1'b0, 8'h00, 3'd0, 1'b0};
      vecs[23] = '{1'b1, 8'h03, 1'b0, 8'h01, 3'd0, 1'b1};
      vecs[24] = '{1'b1, 8'h02, 1'b0, 8'h02, 3'd1, 1'b1};

      // Reset state
      #12;
      chk_all("reset", 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         step(vecs[i].en, vecs[i].req, vecs[i].done);
         chk_all($sformatf("vec%0d", i), vecs[i].g, vecs[i].id, vecs[i].b, 1'b0);
      end

      // Asynchronous reset mid-grant, then arbitration restarts at requester 0
      do_reset();
      step(1'b1, 8'h08, 1'b0);
      chk_all("pre_rst", 8'h08, 3'd3, 1'b1, 1'b0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_rst", 8'h00, 3'd0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk_all("post_rst", 8'h08, 3'd3, 1'b1, 1'b0);
      do_reset();
      step(1'b1, 8'h81, 1'b0);
      chk_all("rst_ptr0", 8'h01, 3'd0, 1'b1, 1'b0);

      // Long hold with no done
      do_reset();
`ifdef RR_TIMEOUT_EN
      for (int k = 1; k <= 16; k++) begin
         step(1'b1, 8'h11, 1'b0);
         chk_all($sformatf("hold%0d", k), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step(1'b1, 8'h11, 1'b0);
      chk_all("forced", 8'h10, 3'd4, 1'b1, 1'b1);
      step(1'b1, 8'h11, 1'b0);
      chk_all("after_forced", 8'h10, 3'd4, 1'b1, 1'b0);
`else
      for (int k = 1; k <= 40; k++) begin
         step(1'b1, 8'h11, 1'b0);
         chk_all($sformatf("hold%0d", k), 8'h01, 3'd0, 1'b1, 1'b0);
      end
      step(1'b1, 8'h11, 1'b1);
      chk_all("hold_done", 8'h10, 3'd4, 1'b1, 1'b0);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
